// File: rtl/eff_clip_multi.sv
// eff_clip_multi: four-stage gain / saturate / shape pipeline for signed samples.
//   stage 0: capture sample, mode, threshold and the current ramped gain
//   stage 1: full-width signed x unsigned gain product
//   stage 2: arithmetic shift by GAIN_FRAC, saturate to DATA_WIDTH
//   stage 3: hard clip / soft clip / fold shaping, registered outputs
// Optional feature macro: EFF_CLIP_FOLD_EN enables fold shaping for mode 3;
// without it mode 3 behaves as hard clip.
module eff_clip_multi #(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 8,
  parameter int GAIN_FRAC  = 2,
  parameter int RAMP_STEP  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic [DATA_WIDTH-2:0]        thresh,
  input  logic [GAIN_WIDTH-1:0]        gain_tgt,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         vld_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         vld_o,
  output logic                         clip_o
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_HARD   = 2'd1;
  localparam logic [1:0] MODE_SOFT   = 2'd2;
  localparam logic [1:0] MODE_FOLD   = 2'd3;
  localparam logic [GAIN_WIDTH-1:0] STEP  = GAIN_WIDTH'(RAMP_STEP);
  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(32'd1 << GAIN_FRAC);
  localparam logic signed [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [GAIN_WIDTH-1:0]        gain_cur, gain_nxt;
  logic                         v0, v1, v2;
  logic signed [DATA_WIDTH-1:0] s0_data;
  logic [GAIN_WIDTH-1:0]        s0_gain;
  logic [1:0]                   s0_mode, s1_mode, s2_mode;
  logic [DATA_WIDTH-2:0]        s0_thr, s1_thr, s2_thr;
  logic signed [PW-1:0]         s1_prod, prod_nxt, data_ext, gain_ext, shifted;
  logic signed [DATA_WIDTH-1:0] s2_x, sat_nxt;
  logic                         s2_sat, ovf;
  logic signed [DATA_WIDTH-1:0] thr_x, neg_thr, y;
  logic [DATA_WIDTH-1:0]        thr_u, mag, excess, soft_mag;
  logic                         clip_nxt;
`ifdef EFF_CLIP_FOLD_EN
  logic [DATA_WIDTH-1:0]        two_thr, fold_mag;
`endif

  // Gain ramp: move toward the target by RAMP_STEP without overshooting.
  always_comb begin
    gain_nxt = gain_cur;
    if (RAMP_STEP == 32'sd0) begin
      gain_nxt = gain_tgt;
    end else if (gain_tgt > gain_cur) begin
      if ((gain_tgt - gain_cur) > STEP) gain_nxt = gain_cur + STEP;
      else                              gain_nxt = gain_tgt;
    end else if (gain_tgt < gain_cur) begin
      if ((gain_cur - gain_tgt) > STEP) gain_nxt = gain_cur - STEP;
      else                              gain_nxt = gain_tgt;
    end else begin
      gain_nxt = gain_cur;
    end
  end

  // Stage 0 capture and gain register; the sample takes gain_cur before its update.
  always_ff @(posedge clk) begin
    if (rst) begin
      gain_cur <= UNITY;
      v0       <= 1'b0;
      s0_data  <= '0;
      s0_gain  <= '0;
      s0_mode  <= '0;
      s0_thr   <= '0;
    end else begin
      v0 <= vld_i;
      if (vld_i) begin
        gain_cur <= gain_nxt;
        s0_data  <= data_i;
        s0_gain  <= gain_cur;
        s0_mode  <= mode;
        s0_thr   <= thresh;
      end
    end
  end

  // Stage 1 product; bypass pre-scales by 2^GAIN_FRAC so stage 2 recovers it exactly.
  always_comb begin
    data_ext = {{(PW-DATA_WIDTH){s0_data[DATA_WIDTH-1]}}, s0_data};
    gain_ext = {{(PW-GAIN_WIDTH){1'b0}}, s0_gain};
    if (s0_mode == MODE_BYPASS) prod_nxt = data_ext <<< GAIN_FRAC;
    else                        prod_nxt = data_ext * gain_ext;
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      s1_prod <= '0;
      s1_mode <= '0;
      s1_thr  <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        s1_prod <= prod_nxt;
        s1_mode <= s0_mode;
        s1_thr  <= s0_thr;
      end
    end
  end

  // Stage 2 arithmetic shift and saturation; overflow when the upper bits disagree.
  always_comb begin
    shifted = s1_prod >>> GAIN_FRAC;
    ovf     = ~(&shifted[PW-1:DATA_WIDTH-1]) & (|shifted[PW-1:DATA_WIDTH-1]);
    if (ovf) sat_nxt = shifted[PW-1] ? SMIN : SMAX;
    else     sat_nxt = shifted[DATA_WIDTH-1:0];
  end

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2      <= 1'b0;
      s2_x    <= '0;
      s2_sat  <= 1'b0;
      s2_mode <= '0;
      s2_thr  <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        s2_x    <= sat_nxt;
        s2_sat  <= ovf;
        s2_mode <= s1_mode;
        s2_thr  <= s1_thr;
      end
    end
  end

  // Stage 3 shaping; magnitude of the most-negative value saturates to SMAX.
  always_comb begin
    thr_u    = {1'b0, s2_thr};
    thr_x    = $signed(thr_u);
    neg_thr  = -thr_x;
    if (s2_x == SMIN)       mag = SMAX;
    else if (s2_x[DATA_WIDTH-1]) mag = -s2_x;
    else                    mag = s2_x;
    excess   = mag - thr_u;
    soft_mag = thr_u + (excess >> 2);
`ifdef EFF_CLIP_FOLD_EN
    two_thr  = {s2_thr, 1'b0};
    if (mag >= two_thr) fold_mag = '0;
    else                fold_mag = two_thr - mag;
`endif
    y = s2_x;
    case (s2_mode)
      MODE_BYPASS: y = s2_x;
      MODE_SOFT: begin
        if (mag <= thr_u)          y = s2_x;
        else if (s2_x[DATA_WIDTH-1]) y = -$signed(soft_mag);
        else                       y = $signed(soft_mag);
      end
`ifdef EFF_CLIP_FOLD_EN
      MODE_FOLD: begin
        if (mag <= thr_u)          y = s2_x;
        else if (s2_x[DATA_WIDTH-1]) y = -$signed(fold_mag);
        else                       y = $signed(fold_mag);
      end
`endif
      MODE_HARD, MODE_FOLD: begin
        if (s2_x > thr_x)        y = thr_x;
        else if (s2_x < neg_thr) y = neg_thr;
        else                     y = s2_x;
      end
      default: y = s2_x;
    endcase
    if (s2_mode == MODE_BYPASS) clip_nxt = 1'b0;
    else                        clip_nxt = s2_sat | (y != s2_x);
  end

  // Output register; data and clip hold while no sample arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_o  <= 1'b0;
      data_o <= '0;
      clip_o <= 1'b0;
    end else begin
      vld_o <= v2;
      if (v2) begin
        data_o <= y;
        clip_o <= clip_nxt;
      end
    end
  end

endmodule
